// File: rtl/word_fifo.sv
// word_fifo: single-clock circular-buffer FIFO placed downstream of the
// write-control FSM.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   wr_en, wr_data write request and data (accepted when not full)
//   rd_en          read request (accepted when not empty)
//   rd_data        registered read data, holds between reads
//   rd_valid       one-cycle pulse when rd_data was updated
//   words          registered occupancy 0..DEPTH (feeds upstream hysteresis)
//   full, empty, almost_full, almost_empty
//                  combinational decodes of words
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
//   clr_err        clears both sticky flags (a new error in the same cycle wins)
module word_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned AF_LEVEL = 5,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] words,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic wr_ok;
  logic rd_ok;

  // Status flags decode the registered count only, so they move on edges.
  always_comb begin
    full         = (words_q == CNT_W'(DEPTH));
    empty        = (words_q == '0);
    almost_full  = (words_q >= CNT_W'(AF_LEVEL));
    almost_empty = (words_q <= CNT_W'(AE_LEVEL));
  end

  always_comb begin
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;

    wptr_d = wr_ok ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = rd_ok ? rptr_q + PTR_W'(1) : rptr_q;

    words_d = words_q;
    case ({wr_ok, rd_ok})
      2'b10:   words_d = words_q + CNT_W'(1);
      2'b01:   words_d = words_q - CNT_W'(1);
      default: words_d = words_q;
    endcase

    rd_data_d  = rd_ok ? mem[rptr_q] : rd_data_q;
    rd_valid_d = rd_ok;

    // Set term is OR'ed outside the clear so a same-cycle error survives clr_err.
    overflow_d  = (wr_en && full)  || (overflow_q  && !clr_err);
    underflow_d = (rd_en && empty) || (underflow_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      words_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      words_q     <= words_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; gating on rst_n keeps reset ahead of a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign words     = words_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_word_fifo.sv
// tb_word_fifo: directed self-checking bench for word_fifo (default parameters).
module tb_word_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] words;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  word_fifo #(
    .WIDTH(8), .DEPTH(8), .CNT_W(4), .AF_LEVEL(5), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .words(words), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       run;
    logic [3:0] wpre;
    int unsigned wmax;
    int unsigned wmin;

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; clr_err = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state held over 5 idle cycles
    for (int i = 0; i < 5; i++) begin
      check("rst_words",  32'(words), 32'd0);
      check("rst_empty",  32'(empty), 32'd1);
      check("rst_full",   32'(full), 32'd0);
      check("rst_ae",     32'(almost_empty), 32'd1);
      check("rst_af",     32'(almost_full), 32'd0);
      check("rst_rdval",  32'(rd_valid), 32'd0);
      check("rst_rddata", 32'(rd_data), 32'd0);
      check("rst_ovf",    32'(overflow), 32'd0);
      check("rst_unf",    32'(underflow), 32'd0);
      tick();
    end

    // Read from empty sets underflow, count stays 0
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("unf_set",   32'(underflow), 32'd1);
    check("unf_words", 32'(words), 32'd0);
    check("unf_rdval", 32'(rd_valid), 32'd0);
    tick();
    check("unf_hold",  32'(underflow), 32'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("unf_clr",   32'(underflow), 32'd0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick();
      check("fill_words", 32'(words), 32'(i));
      check("fill_af",    32'(almost_full), 32'(i >= 5));
      check("fill_full",  32'(full), 32'(i == 8));
      check("fill_ae",    32'(almost_empty), 32'(i <= 2));
      check("fill_empty", 32'(empty), 32'd0);
    end
    wr_data = 8'h09; tick(); wr_en = 1'b0;
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_words", 32'(words), 32'd8);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf_clr",   32'(overflow), 32'd0);
    check("ovf_clr_w", 32'(words), 32'd8);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1; tick();
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data",  32'(rd_data), 32'(i));
      check("drain_words", 32'(words), 32'(8 - i));
      check("drain_ae",    32'(almost_empty), 32'((8 - i) <= 2));
      check("drain_empty", 32'(empty), 32'(i == 8));
    end
    rd_en = 1'b0; tick();
    check("drain_vlow", 32'(rd_valid), 32'd0);
    check("drain_hold", 32'(rd_data), 32'h08);
    check("drain_unf",  32'(underflow), 32'd0);

    // Wrap: write 5, read 3, then 10 concurrent cycles
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i); tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; tick();
      check("wrap_rd", 32'(rd_data), 32'(8'h10 + i));
    end
    check("wrap_words2", 32'(words), 32'd2);
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h15 + k); tick();
      check("conc_data",  32'(rd_data), 32'(8'h13 + k));
      check("conc_valid", 32'(rd_valid), 32'd1);
      check("conc_words", 32'(words), 32'd2);
    end
    wr_en = 1'b0;
    tick(); check("tail_rd0", 32'(rd_data), 32'h1D);
    tick(); check("tail_rd1", 32'(rd_data), 32'h1E);
    rd_en = 1'b0;
    check("tail_empty", 32'(empty), 32'd1);
    check("tail_ovf",   32'(overflow), 32'd0);
    check("tail_unf",   32'(underflow), 32'd0);

    // Simultaneous read+write at full: read wins, write rejected
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i); tick();
    end
    check("bfull_full", 32'(full), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF; tick();
    wr_en = 1'b0;
    check("bfull_words", 32'(words), 32'd7);
    check("bfull_ovf",   32'(overflow), 32'd1);
    check("bfull_data",  32'(rd_data), 32'h30);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("bfull_drain", 32'(rd_data), 32'(8'h30 + i));
    end
    rd_en = 1'b0;
    check("bfull_empty", 32'(words), 32'd0);

    // Simultaneous read+write at empty: write wins, read rejected
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("bempty_words", 32'(words), 32'd1);
    check("bempty_unf",   32'(underflow), 32'd1);
    check("bempty_val",   32'(rd_valid), 32'd0);
    check("bempty_hold",  32'(rd_data), 32'h37);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);
    rd_en = 1'b1; tick();
    check("bempty_rd", 32'(rd_data), 32'h55);
    // clr_err together with a new underflow: the set wins
    clr_err = 1'b1; tick(); clr_err = 1'b0; rd_en = 1'b0;
    check("setwins_unf", 32'(underflow), 32'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("setwins_clr", 32'(underflow), 32'd0);

    // Closed loop: registered upstream FSM (stop at >=5, restart at <=2),
    // reader pops every 4th cycle
    run = 1'b0; wmax = 0; wmin = 8;
    for (int c = 0; c < 60; c++) begin
      wr_en = run; wr_data = 8'hAA; rd_en = ((c % 4) == 3);
      wpre = words;
      if (wpre >= 4'd5) run = 1'b0;
      else if (wpre <= 4'd2) run = 1'b1;
      tick();
      check("loop_nofull", 32'(full), 32'd0);
      check("loop_ovf",    32'(overflow), 32'd0);
      check("loop_unf",    32'(underflow), 32'd0);
      if (rd_valid) check("loop_data", 32'(rd_data), 32'hAA);
      if (c >= 2) begin
        if (32'(words) > wmax) wmax = 32'(words);
        if (32'(words) < wmin) wmin = 32'(words);
      end
    end
    check("loop_max", wmax, 32'd6);
    check("loop_min", wmin, 32'd2);

    // Reset mid-run with requests active
    wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b0; rst_n = 1'b0; tick();
    check("mrst_words", 32'(words), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_valid", 32'(rd_valid), 32'd0);
    check("mrst_data",  32'(rd_data), 32'd0);
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; tick();
    check("mrst_after", 32'(words), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
